// File: rtl/aes_host_seq.sv
// Initiator-side sequencer for the word-serial AES-128 core: loads key+block, waits for done, reads ciphertext.
// Optional WAIT timeout with core reset and sticky err is compiled in with AES_HOST_WAIT_TIMEOUT_EN.
module aes_host_seq
`ifdef AES_HOST_WAIT_TIMEOUT_EN
#(
    parameter int unsigned WAIT_MAX = 4096
)
`endif
(
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_key,
    input  logic [127:0] req_block,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_block,
    output logic         aes_start_n,
    output logic         aes_start_read_n,
    output logic [31:0]  aes_dword_in,
    input  logic [31:0]  aes_dword_out,
    input  logic         aes_done,
    output logic         busy
`ifdef AES_HOST_WAIT_TIMEOUT_EN
    ,
    output logic         aes_reset_n,
    output logic         err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD,
        S_WAIT,
        S_RDREQ,
        S_READ,
        S_RSP
`ifdef AES_HOST_WAIT_TIMEOUT_EN
        ,
        S_CRST
`endif
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [255:0]   shadow_q, shadow_d;
    logic           req_ready_q, req_ready_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [127:0]   rsp_block_q, rsp_block_d;
    logic           aes_start_n_q, aes_start_n_d;
    logic           aes_start_read_n_q, aes_start_read_n_d;
    logic [31:0]    aes_dword_in_q, aes_dword_in_d;
    logic           busy_q, busy_d;

`ifdef AES_HOST_WAIT_TIMEOUT_EN
    localparam int unsigned WCW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           aes_reset_n_q, aes_reset_n_d;
    logic           err_q, err_d;
`endif

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        shadow_d           = shadow_q;
        rsp_valid_d        = rsp_valid_q;
        rsp_block_d        = rsp_block_q;
        aes_start_n_d      = 1'b1;
        aes_start_read_n_d = 1'b1;
        aes_dword_in_d     = 32'h0;
`ifdef AES_HOST_WAIT_TIMEOUT_EN
        wait_cnt_d         = wait_cnt_q;
        aes_reset_n_d      = 1'b1;
        err_d              = err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    shadow_d      = {req_key, req_block};
                    aes_start_n_d = 1'b0;
                    state_d       = S_START;
`ifdef AES_HOST_WAIT_TIMEOUT_EN
                    err_d         = 1'b0;
`endif
                end
            end
            // Output word is registered, so each cycle presents the word for the next cycle.
            S_START: begin
                aes_dword_in_d = shadow_q[255:224];
                shadow_d       = {shadow_q[223:0], 32'h0};
                cnt_d          = 3'd0;
                state_d        = S_LOAD;
            end
            S_LOAD: begin
                if (cnt_q == 3'd7) begin
                    cnt_d   = 3'd0;
                    state_d = S_WAIT;
`ifdef AES_HOST_WAIT_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end else begin
                    aes_dword_in_d = shadow_q[255:224];
                    shadow_d       = {shadow_q[223:0], 32'h0};
                    cnt_d          = cnt_q + 3'd1;
                end
            end
            S_WAIT: begin
                if (aes_done) begin
                    aes_start_read_n_d = 1'b0;
                    state_d            = S_RDREQ;
                end
`ifdef AES_HOST_WAIT_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LAST) begin
                    aes_reset_n_d = 1'b0;
                    err_d         = 1'b1;
                    rsp_block_d   = '0;
                    cnt_d         = 3'd0;
                    state_d       = S_CRST;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
`endif
            end
            S_RDREQ: begin
                cnt_d   = 3'd0;
                state_d = S_READ;
            end
            S_READ: begin
                // Column0 arrives first and ends up in the top word after four shifts.
                rsp_block_d = {rsp_block_q[95:0], aes_dword_out};
                if (cnt_q == 3'd3) begin
                    cnt_d       = 3'd0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_RSP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
`ifdef AES_HOST_WAIT_TIMEOUT_EN
            S_CRST: begin
                if (cnt_q == 3'd0) begin
                    aes_reset_n_d = 1'b0;
                    cnt_d         = 3'd1;
                end else begin
                    cnt_d       = 3'd0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Ready only rises after a full cycle in IDLE, giving the one-cycle bubble after RSP.
        req_ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= S_IDLE;
            cnt_q              <= 3'd0;
            shadow_q           <= '0;
            req_ready_q        <= 1'b0;
            rsp_valid_q        <= 1'b0;
            rsp_block_q        <= '0;
            aes_start_n_q      <= 1'b1;
            aes_start_read_n_q <= 1'b1;
            aes_dword_in_q     <= 32'h0;
            busy_q             <= 1'b0;
`ifdef AES_HOST_WAIT_TIMEOUT_EN
            wait_cnt_q         <= '0;
            aes_reset_n_q      <= 1'b1;
            err_q              <= 1'b0;
`endif
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            shadow_q           <= shadow_d;
            req_ready_q        <= req_ready_d;
            rsp_valid_q        <= rsp_valid_d;
            rsp_block_q        <= rsp_block_d;
            aes_start_n_q      <= aes_start_n_d;
            aes_start_read_n_q <= aes_start_read_n_d;
            aes_dword_in_q     <= aes_dword_in_d;
            busy_q             <= busy_d;
`ifdef AES_HOST_WAIT_TIMEOUT_EN
            wait_cnt_q         <= wait_cnt_d;
            aes_reset_n_q      <= aes_reset_n_d;
            err_q              <= err_d;
`endif
        end
    end

    assign req_ready        = req_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_block        = rsp_block_q;
    assign aes_start_n      = aes_start_n_q;
    assign aes_start_read_n = aes_start_read_n_q;
    assign aes_dword_in     = aes_dword_in_q;
    assign busy             = busy_q;
`ifdef AES_HOST_WAIT_TIMEOUT_EN
    assign aes_reset_n      = aes_reset_n_q;
    assign err              = err_q;
`endif

endmodule

// File: tb/tb_aes_host_seq.sv
// Directed bench for aes_host_seq with a behavioural word-serial core model (FIPS-197 C.1 / B vectors).
module tb_aes_host_seq;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [127:0] req_key = '0;
    logic [127:0] req_block = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_block;
    logic         aes_start_n;
    logic         aes_start_read_n;
    logic [31:0]  aes_dword_in;
    logic [31:0]  aes_dword_out = 32'h0;
    logic         aes_done = 1'b0;
    logic         busy;
    logic         core_rst_n;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

`ifdef AES_HOST_WAIT_TIMEOUT_EN
    logic err;
    aes_host_seq #(.WAIT_MAX(16)) dut (
`else
    assign core_rst_n = 1'b1;
    aes_host_seq dut (
`endif
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_key          (req_key),
        .req_block        (req_block),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_block        (rsp_block),
        .aes_start_n      (aes_start_n),
        .aes_start_read_n (aes_start_read_n),
        .aes_dword_in     (aes_dword_in),
        .aes_dword_out    (aes_dword_out),
        .aes_done         (aes_done),
        .busy             (busy)
`ifdef AES_HOST_WAIT_TIMEOUT_EN
        ,
        .aes_reset_n      (core_rst_n),
        .err              (err)
`endif
    );

    // Core model: observes strobes mid-cycle and drives done/data for the remainder of that cycle.
    logic [31:0]  loaded [8];
    logic [127:0] core_ct = '0;
    int  done_dly = 5;
    int  ld_idx = 0, rd_idx = 0, wait_cnt = 0;
    bit  loading = 0, waiting = 0, reading = 0;
    int  last_load_cyc = 0, rdreq_cyc = 0, rstn_low_total = 0;

    always @(negedge clk) begin
        if (!core_rst_n) rstn_low_total++;
        if (reset || !core_rst_n) begin
            loading = 0; waiting = 0; reading = 0;
            aes_done = 1'b0;
            aes_dword_out = 32'hdeadbeef;
        end else begin
            if (reading) begin
                aes_dword_out = core_ct[127-32*rd_idx -: 32];
                rd_idx++;
                if (rd_idx == 4) reading = 0;
            end else begin
                aes_dword_out = 32'hdeadbeef;
            end
            if (!aes_start_read_n) begin
                reading = 1; rd_idx = 0; waiting = 0;
                aes_done = 1'b0;
                rdreq_cyc = cyc;
            end
            if (loading) begin
                loaded[ld_idx] = aes_dword_in;
                ld_idx++;
                if (ld_idx == 8) begin
                    loading = 0; waiting = 1; wait_cnt = 0;
                    last_load_cyc = cyc;
                    if (done_dly == 0) aes_done = 1'b1;
                end
            end else if (waiting) begin
                wait_cnt++;
                if (done_dly > 0 && wait_cnt >= done_dly) aes_done = 1'b1;
            end
            if (!aes_start_n) begin
                loading = 1; ld_idx = 0;
            end
        end
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_req_ready"}, req_ready, 0);
        check_val({pfx, "_rsp_valid"}, rsp_valid, 0);
        check_val({pfx, "_rsp_block"}, rsp_block, 0);
        check_val({pfx, "_start_n"}, aes_start_n, 1);
        check_val({pfx, "_start_read_n"}, aes_start_read_n, 1);
        check_val({pfx, "_dword_in"}, aes_dword_in, 0);
        check_val({pfx, "_busy"}, busy, 0);
    endtask

    // Called at a negedge; returns at the negedge of the START cycle.
    task automatic send_req(input logic [127:0] k, input logic [127:0] b, input bit hold);
        int t;
        req_key = k; req_block = b; req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_val("req_accept", req_ready, 1);
        hs_cyc = cyc;
        @(negedge clk);
        if (!hold) begin
            req_valid = 1'b0;
            req_key = ~k;
            req_block = ~b;
        end
    endtask

    task automatic wait_rsp(output int lat);
        int t;
        t = 0;
        while (!rsp_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_val("rsp_valid_seen", rsp_valid, 1);
        lat = cyc - hs_cyc;
        $display("txn: key=%h rsp_block=%h latency=%0d", dut.shadow_q == 0 ? req_key : req_key, rsp_block, lat);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_val("rsp_drop", rsp_valid, 0);
    endtask

    task automatic check_loaded(input logic [127:0] k, input logic [127:0] b);
        logic [255:0] exp_ld;
        exp_ld = {k, b};
        for (int i = 0; i < 8; i++)
            check_val($sformatf("load_w%0d", i), loaded[i], exp_ld[255-32*i -: 32]);
    endtask

    initial begin
        int lat, bad;
        logic [127:0] snap;

        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);
        check_val("ready_after_reset", req_ready, 1);

        // FIPS-197 C.1, done 20 cycles after the last load word.
        core_ct = C1_CT; done_dly = 20;
        send_req(C1_KEY, C1_PT, 0);
        wait_rsp(lat);
        check_val("c1_latency", lat, 35);
        check_val("c1_ct", rsp_block, C1_CT);
        check_val("c1_busy", busy, 1);
        check_loaded(C1_KEY, C1_PT);
        finish_rsp();
        check_val("c1_idle_busy", busy, 0);

        // Done already high on WAIT entry.
        core_ct = B_CT; done_dly = 0;
        send_req(B_KEY, B_PT, 0);
        wait_rsp(lat);
        check_val("fast_rdreq_gap", rdreq_cyc - last_load_cyc, 2);
        check_val("fast_latency", lat, 16);
        check_val("fast_ct", rsp_block, B_CT);
        check_val("fast_load_w0", loaded[0], 32'h2b7e1516);
        check_val("fast_load_w7", loaded[7], 32'he0370734);
        finish_rsp();

        // Backpressure with a pending request held throughout.
        core_ct = C1_CT; done_dly = 5;
        send_req(C1_KEY, C1_PT, 1);
        wait_rsp(lat);
        check_val("bp_latency", lat, 20);
        snap = rsp_block;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_block !== snap || req_ready !== 1'b0) bad++;
        end
        check_val("bp_stable_bad_cycles", bad, 0);
        check_val("bp_ct", snap, C1_CT);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_val("bp_rsp_drop", rsp_valid, 0);
        check_val("bp_bubble_ready", req_ready, 0);
        @(negedge clk);
        check_val("bp_ready_2cyc", req_ready, 1);
        hs_cyc = cyc;
        @(negedge clk);
        check_val("bp_start_strobe", aes_start_n, 0);
        req_valid = 1'b0;
        wait_rsp(lat);
        check_val("bp2_latency", lat, 20);
        check_val("bp2_ct", rsp_block, C1_CT);
        finish_rsp();

        // Reset pulse during LOAD cnt=5.
        send_req(C1_KEY, C1_PT, 0);
        repeat (6) @(negedge clk);
        check_val("load5_word", aes_dword_in, 32'h44556677);
        #2 reset = 1'b1;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        #2 reset = 1'b0;
        send_req(C1_KEY, C1_PT, 0);
        wait_rsp(lat);
        check_val("postrst_latency", lat, 20);
        check_val("postrst_ct", rsp_block, C1_CT);
        check_loaded(C1_KEY, C1_PT);
        finish_rsp();

`ifdef AES_HOST_WAIT_TIMEOUT_EN
        begin
            int low0;
            low0 = rstn_low_total;
            done_dly = -1;
            send_req(B_KEY, B_PT, 0);
            wait_rsp(lat);
            check_val("to_latency", lat, 28);
            check_val("to_rstn_low_cycles", rstn_low_total - low0, 2);
            check_val("to_err", err, 1);
            check_val("to_block_zero", rsp_block, 0);
            finish_rsp();
            check_val("to_err_sticky", err, 1);
            core_ct = C1_CT; done_dly = 5;
            req_key = C1_KEY; req_block = C1_PT;
            send_req(C1_KEY, C1_PT, 0);
            check_val("to_err_cleared", err, 0);
            wait_rsp(lat);
            check_val("to_next_ct", rsp_block, C1_CT);
            finish_rsp();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_host_seq.md
Name: aes_host_seq

Overview:
- Initiator-side sequencer for the AES-128 core's word-serial port; drives the core from the opposite end of that interface.
- Accepts one 128-bit key plus one 128-bit plaintext block per transaction over a valid/ready request channel.
- Serialises the key and block into the core, waits for the core's done flag, reads back four ciphertext words, and returns the ciphertext over a valid/ready response channel.
- Sits between the system bus/DMA glue and the aes core top.

Parameters:
- WAIT_MAX, 4096: maximum cycles spent in WAIT for core done; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer accepts request
- req_key  in  128  cipher key; word0 = [127:96] ... word3 = [31:0]
- req_block  in  128  plaintext; column0 = [127:96] ... column3 = [31:0]
- rsp_valid  out  1  ciphertext available
- rsp_ready  in  1  consumer accepts ciphertext
- rsp_block  out  128  ciphertext; column0 = [127:96]
- aes_start_n  out  1  active-low start-write strobe to core
- aes_start_read_n  out  1  active-low start-read strobe to core
- aes_dword_in  out  32  word bus to core
- aes_dword_out  in  32  word bus from core
- aes_done  in  1  core ciphertext-ready flag
- busy  out  1  high in any state other than IDLE
- aes_reset_n  out  1  core reset; only with AES_HOST_WAIT_TIMEOUT_EN, otherwise absent
- err  out  1  timeout sticky flag; only with AES_HOST_WAIT_TIMEOUT_EN, otherwise absent

Behaviour:
- Core protocol, fixed:
  - aes_start_n is low for exactly one cycle.
  - On the 8 following cycles the core samples aes_dword_in: key word0..3, then plaintext column0..3.
  - Later, aes_done goes high.
  - aes_start_read_n is low for exactly one cycle.
  - The core presents ciphertext column0..3 on aes_dword_out on the 4 cycles following the strobe.
- Reset values: req_ready=0, rsp_valid=0, rsp_block=0, aes_start_n=1, aes_start_read_n=1, aes_dword_in=0, busy=0, err=0, aes_reset_n=1; FSM in IDLE; all counters 0.
- FSM states: IDLE, START, LOAD, WAIT, RDREQ, READ, RSP.
- IDLE:
  - req_ready=1 (registered, asserted the cycle after entering IDLE).
  - On req_valid & req_ready, capture key and block into a 256-bit shadow register and go to START.
  - req_ready is 0 in every other state.
- START: aes_start_n=0 for one cycle; load counter cleared; go to LOAD.
- LOAD:
  - 8 cycles; counter 0..7.
  - aes_dword_in = key word[cnt] for cnt 0-3, block column[cnt-4] for cnt 4-7.
  - After cnt=7, go to WAIT and drive aes_dword_in=0.
- WAIT: hold until aes_done=1, then go to RDREQ. An aes_done already high on WAIT entry is honoured on the same cycle.
- RDREQ: aes_start_read_n=0 for one cycle; go to READ.
- READ:
  - 4 cycles; counter 0..3.
  - Shift aes_dword_out into rsp_block column[cnt].
  - After cnt=3, go to RSP.
- RSP:
  - rsp_valid=1; rsp_block stable until handshake.
  - On rsp_valid & rsp_ready, rsp_valid drops the next cycle and the FSM returns to IDLE.
  - rsp_ready=0 holds indefinitely (backpressure); no new request is accepted while in RSP.
- Latency, request handshake to rsp_valid: 1 + 8 + W + 1 + 4 + 1 cycles, where W is the WAIT dwell (>= 1).
- Inputs are ignored outside the handshake: req_key/req_block may change after acceptance; aes_dword_out is ignored outside READ; aes_done is ignored outside WAIT.
- Asynchronous reset mid-transaction: all registers return to reset values immediately. The core is not informed; the system reset resets both blocks together.
- Back-to-back: a new request can be accepted on the cycle after the RSP→IDLE transition (one-cycle bubble), never in the same cycle as the rsp handshake.

Optional Feature:
- Macro: AES_HOST_WAIT_TIMEOUT_EN.
- Enabled:
  - A WAIT-dwell counter runs during WAIT.
  - On reaching WAIT_MAX without aes_done, the sequencer drives aes_reset_n=0 for 2 cycles and sets sticky err=1.
  - It then returns to RSP with rsp_block=0.
  - err clears only on reset or on the next accepted request.
- Disabled: no counter, no err, no aes_reset_n ports; WAIT waits forever.

Test Plan:
- FIPS-197 C.1 with a behavioural core model:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff.
  - Response: aes_dword_in sequence 00010203, 04050607, 08090a0b, 0c0d0e0f, 00112233, 44556677, 8899aabb, ccddeeff.
  - Response: rsp_block = 69c4e0d86a7b0430d8cdb78070b4c55a.
- Core model asserts aes_done 20 cycles after the last load word -> rsp_valid rises exactly 35 cycles after the request handshake.
- Hold rsp_ready=0 for 50 cycles with req_valid=1 throughout -> rsp_valid and rsp_block stable, req_ready=0. Release rsp_ready -> request accepted 2 cycles later.
- Assert reset for 1 cycle during LOAD cnt=5 -> all outputs at reset values immediately. Next transaction produces the correct ciphertext.
- Core model asserts aes_done already high when WAIT is entered -> aes_start_read_n pulses on the following cycle; no extra WAIT cycle.
- With AES_HOST_WAIT_TIMEOUT_EN and WAIT_MAX=16, aes_done never asserted -> aes_reset_n low 2 cycles, err=1, rsp_block=0. err clears on the next request handshake.
